iter_divider: RTL
=================

# iter_divider

Iterative 32-bit signed integer divider for the CPU's multiply/divide unit: the subtractive counterpart to the ALU's carry-lookahead adder path. It uses one shift-and-subtract step per clock (restoring division), so the result is ready after a fixed latency. It latches operands on a start pulse and returns the quotient, the remainder and an exception flag, with a one-cycle ready pulse to the pipeline stall logic.

## Interface
- Parameters: none. Width is fixed at 32 bits.
- `clock`  in  1  — rising-edge clock for all state.
- `resetn`  in  1  — synchronous, active-low reset.
- `ctrl_DIV`  in  1  — start pulse; operands are sampled on the edge where this is high.
- `data_operandA`  in  32  — dividend, two's complement.
- `data_operandB`  in  32  — divisor, two's complement.
- `data_result`  out  32  — quotient, truncated toward zero.
- `data_remainder`  out  32  — remainder; it takes the sign of the dividend.
- `data_exception`  out  1  — set on divide-by-zero or on 0x80000000 / 0xFFFFFFFF.
- `data_resultRDY`  out  1  — one-cycle pulse; outputs are valid while it is high.
- `busy`  out  1  — high from the edge after the start through the cycle before the ready pulse.

## Operation
- States: IDLE, RUN, FIX, DONE. A 6-bit iteration counter runs 0..31.
- IDLE
  - On `ctrl_DIV`=1, latch |A|, |B|, sign(A) and sign(A)^sign(B). Clear the 33-bit partial remainder. Load the quotient register with |A|.
  - If B=0: go to DONE with quotient=0, remainder=A, exception=1.
  - Otherwise: go to RUN with counter=0.
- RUN (each cycle)
  - Shift {rem,quo} left by 1.
  - Trial subtract: rem−|B| in 33 bits.
  - If the result is non-negative: rem ← difference, quo[0] ← 1. Otherwise: keep rem, quo[0] ← 0.
  - Counter increments. After iteration 31, go to FIX.
- FIX
  - Negate the quotient if the sign-XOR bit is set.
  - Negate the remainder if sign(A) is set.
  - Set exception if A=0x80000000 and B=0xFFFFFFFF. In that case quotient=0x80000000 (wrapped) and remainder=0.
  - Go to DONE.
- DONE
  - `data_resultRDY`=1 for exactly this cycle, then return to IDLE.
  - `ctrl_DIV` high in DONE is accepted as a new start, behaving as in IDLE.
- `ctrl_DIV` during RUN or FIX is ignored. The operation in flight is unaffected.
- Changing the operand inputs after the start edge has no effect. Only the latched copies are used.
- Output hold rules:
  - `data_result`, `data_remainder` and `data_exception` hold their last values until the next completed operation.
  - `data_exception` is cleared at the start of each new operation.
- Abs of 0x80000000 is 0x80000000, treated as unsigned 2^31. No special path is needed for this except the overflow flag.

## Timing
- Start sampled at edge 0.
- Normal divide:
  - RUN occupies the cycles after edges 1..32.
  - FIX follows edge 33.
  - DONE, with `data_resultRDY`=1, follows edge 34.
  - Total latency: 34 cycles from start to ready.
- Divide-by-zero: `data_resultRDY`=1 in the cycle after edge 1 (latency 1). `busy` is never asserted.
- `busy`=1 from edge 1 through the FIX cycle, and is 0 in DONE.
- Back-to-back: a start in the DONE cycle produces the next ready pulse 34 cycles later.
- Reset (`resetn`=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0: `data_result`, `data_remainder`, `data_exception`, `data_resultRDY`, `busy`.
  - Reset mid-operation aborts the operation and produces no ready pulse.
  - Reset has priority over `ctrl_DIV` on the same edge.

## Test plan
- 100 / 7: ready exactly 34 cycles after start; result=14, remainder=2, exception=0. Busy is high for 33 cycles.
- −100 / 7 → −14, rem −2. Then 100 / −7 → −14, rem 2. Then −100 / −7 → 14, rem −2. Run all three back-to-back, each started in the prior DONE cycle.
- 5 / 0: ready 1 cycle after start; exception=1, result=0, remainder=5. A following 9 / 3 → 3, rem 0, exception cleared.
- 0x80000000 / 0xFFFFFFFF → result 0x80000000, rem 0, exception=1. Also 0x80000000 / 1 → 0x80000000, exception=0.
- Start 1000 / 3, then pulse `ctrl_DIV` at cycle 10 with different operands and toggle the operand inputs: result 333, rem 1, ready still at cycle 34.
- Start 1000 / 3, assert `resetn`=0 at cycle 20:
  - All outputs are 0 and no ready pulse appears.
  - A new start of 7 / 2 completes 34 cycles later with 3, rem 1.
- Random: 10k signed pairs against a reference model using C-style truncating division, checking quotient, remainder, exception and latency.

Source files
------------

// File: rtl/iter_divider_if.sv
// Handshake and data bundle for the iterative signed divider.
//   master : drives the start pulse and both operands, reads the results
//   slave  : the divider itself
// Signals:
//   ctrl_DIV        start pulse; operands are sampled on the edge where it is high
//   data_operandA   dividend, two's complement
//   data_operandB   divisor, two's complement
//   data_result     quotient, truncated toward zero
//   data_remainder  remainder, takes the sign of the dividend
//   data_exception  divide-by-zero or 0x80000000 / 0xFFFFFFFF
//   data_resultRDY  one-cycle pulse; results are valid while it is high
//   busy            high while a divide is in flight
interface iter_divider_if;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/iter_divider.sv
// Iterative 32-bit signed restoring divider, one quotient bit per clock.
// Ports:
//   clock   rising-edge clock
//   resetn  synchronous active-low reset; clears state and all outputs
//   dif     iter_divider_if.slave bundle (start, operands, results, ready, busy)
// Operands are latched as magnitudes plus sign bits; 32 shift/subtract steps
// produce the unsigned quotient/remainder, a FIX cycle applies signs.
// busy/ready/results are registered one cycle behind the FSM state, which
// gives a 34-cycle start-to-ready latency (1 cycle for divide-by-zero).
module iter_divider (
    input  logic          clock,
    input  logic          resetn,
    iter_divider_if.slave dif
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] absb_q, absb_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_x_q, sign_x_d;
    logic        ovf_q, ovf_d;

    // Final values of the operation in flight, published on the ready pulse.
    logic [31:0] res_q, res_d;
    logic [31:0] rmd_q, rmd_d;
    logic        exc_q, exc_d;

    // Registered outputs.
    logic [31:0] out_res_q, out_res_d;
    logic [31:0] out_rmd_q, out_rmd_d;
    logic        out_exc_q, out_exc_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        start_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        absb_d    = absb_q;
        sign_a_d  = sign_a_q;
        sign_x_d  = sign_x_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        rmd_d     = rmd_q;
        exc_d     = exc_q;
        out_res_d = out_res_q;
        out_rmd_d = out_rmd_q;
        out_exc_d = out_exc_q;

        // Remainder stays below |B| <= 2^31, so the shifted value fits in 33 bits.
        rem_sh   = {rem_q[31:0], quo_q[31]};
        diff     = rem_sh - {1'b0, absb_q};
        start_ok = dif.ctrl_DIV && ((state_q == IDLE) || (state_q == DONE));

        ready_d  = (state_q == DONE);
        busy_d   = (state_q == RUN) || (state_q == FIX);

        // Publish the completed operation in step with the ready pulse.
        if (state_q == DONE) begin
            out_res_d = res_q;
            out_rmd_d = rmd_q;
            out_exc_d = exc_q;
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_ok) begin
                    // In DONE the output registers are busy publishing the
                    // finished result, so only clear the flag from IDLE.
                    if (state_q == IDLE) out_exc_d = 1'b0;
                    sign_a_d = dif.data_operandA[31];
                    sign_x_d = dif.data_operandA[31] ^ dif.data_operandB[31];
                    absb_d   = dif.data_operandB[31] ? -dif.data_operandB : dif.data_operandB;
                    quo_d    = dif.data_operandA[31] ? -dif.data_operandA : dif.data_operandA;
                    rem_d    = 33'd0;
                    ovf_d    = (dif.data_operandA == 32'h8000_0000) &&
                               (dif.data_operandB == 32'hFFFF_FFFF);
                    cnt_d    = 6'd0;
                    if (dif.data_operandB == 32'd0) begin
                        state_d = DONE;
                        res_d   = 32'd0;
                        rmd_d   = dif.data_operandA;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!diff[32]) begin
                    rem_d = diff;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                // |0x80000000| / 1 already yields 0x80000000 with remainder 0,
                // so the overflow case only needs the flag.
                res_d   = sign_x_q ? -quo_q : quo_q;
                rmd_d   = sign_a_q ? -rem_q[31:0] : rem_q[31:0];
                exc_d   = ovf_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        absb_q   <= absb_d;
        sign_a_q <= sign_a_d;
        sign_x_q <= sign_x_d;
        ovf_q    <= ovf_d;
        res_q    <= res_d;
        rmd_q    <= rmd_d;
        exc_q    <= exc_d;
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            out_res_q <= 32'd0;
            out_rmd_q <= 32'd0;
            out_exc_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_res_q <= out_res_d;
            out_rmd_q <= out_rmd_d;
            out_exc_q <= out_exc_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign dif.data_result    = out_res_q;
    assign dif.data_remainder = out_rmd_q;
    assign dif.data_exception = out_exc_q;
    assign dif.data_resultRDY = ready_q;
    assign dif.busy           = busy_q;

endmodule
